inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Fetch stage placed in front of the IF/ID register of the 5-stage MIPS pipeline.
- Issues in-order word fetches to instruction memory through a valid/ready request channel.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO.
- Presents one instruction per cycle to decode; flushes on branch/jump redirect.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum of (queued + outstanding) fetches; power of 2, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- redirect_valid  in  1  taken branch/jump from EX/MEM
- redirect_pc  in  32  new fetch target
- id_stall  in  1  decode cannot accept (hazard stall)
- if_valid  out  1  if_inst/if_pc_plus_4 valid
- if_inst  out  32  instruction to IF/ID; 32'h0 (NOP) when !if_valid
- if_pc_plus_4  out  32  PC of if_inst plus 4; 0 when !if_valid
- occupancy  out  $clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=RUN.
  - Outputs on reset: imem_req_valid=0, if_valid=0, if_inst=0, if_pc_plus_4=0, occupancy=0.
- Request issue:
  - imem_req_valid=1 when count+outstanding<DEPTH and !redirect_valid.
  - imem_req_addr=fetch_pc.
  - On handshake: fetch_pc+=4, wrapping mod 2^32.
  - A separate tag FIFO, or equivalent order, records the PC of each outstanding request.
- Response:
  - A non-dropped response pushes {inst, pc+4}; outstanding decrements.
  - Overflow is impossible by the credit rule. Assert on violation.
- Pop: when if_valid && !id_stall, the head entry is removed.
  - Default latency: response to if_valid is 1 cycle.
  - if_valid is asserted only when the FIFO is non-empty.
- Redirect, which has the highest priority:
  - FIFO is cleared. Any pop in the same cycle is ignored.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - drop_cnt=outstanding, including any request accepted in that same cycle.
  - A response arriving in the same cycle is discarded and not counted in drop_cnt.
  - Next state = DRAIN if drop_cnt>0, else RUN.
- FSM:
  - RUN: responses are pushed.
  - DRAIN: responses are discarded and drop_cnt decrements; go to RUN when drop_cnt reaches 0.
  - New requests may issue during DRAIN; their responses follow the dropped ones in order.
  - A redirect during DRAIN recomputes drop_cnt from the current outstanding count.
- Simultaneous push and pop: count is unchanged. Full FIFO with a pop: the request credit becomes available the next cycle, not combinationally.
- id_stall held indefinitely: the queue fills and requests stop. No data is lost.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When the FIFO is empty, in RUN, with no redirect, a valid response drives if_valid/if_inst/if_pc_plus_4 combinationally in the same cycle.
  - If it is not popped (id_stall), it is written to the FIFO.
  - Latency is 0.
- Undefined: every response goes through the FIFO (latency 1). No combinational path from imem_rsp_* to if_*.

Decomposition:
- Package ifq_pkg:
  - PC_W=32, NOP_INST=32'h0, RESET_VECTOR.
  - State enum {RUN, DRAIN}.
  - Typedef of the entry struct {inst[31:0], pc_plus_4[31:0]}.
- Sub-module ifq_fifo:
  - Parameterised synchronous FIFO: push, pop, clear, full, empty, count.
  - Instantiated for entries; a second instance holds outstanding PCs.

Test Plan:
- Reset, then memory ready with 1-cycle response, id_stall=0 → addresses 0,4,8,… issued; if_inst follows the memory image; if_pc_plus_4=4,8,12,…
- id_stall=1 for 10 cycles, DEPTH=4 → exactly 4 requests are outstanding or queued, then imem_req_valid=0. Release the stall → 4 instructions pop in order with no loss.
- 2 requests outstanding, redirect_pc=32'h0000_0103 → next address 0x100. The 2 stale responses are dropped (DRAIN for 2 responses). First if_pc_plus_4=0x104.
- Redirect in the same cycle as a response and a pop → FIFO cleared, response discarded, occupancy=0 next cycle.
- fetch_pc=32'hFFFF_FFFC → next address 32'h0000_0000; if_pc_plus_4=0 for that entry.
- IFQ_BYPASS_EN defined, empty FIFO → response at cycle N gives if_valid=1 at cycle N; undefined → if_valid=1 at N+1.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the instruction fetch queue:
//   PC_W          - program-counter width
//   NOP_INST      - instruction shown to decode when nothing is valid
//   RESET_VECTOR  - default fetch address after reset
//   ifq_state_e   - RUN (responses kept) / DRAIN (stale responses dropped)
//   ifq_entry_t   - one queued instruction with the PC+4 that goes with it
//   word_align()  - clears the byte-offset bits of a fetch target
// -----------------------------------------------------------------------------
package ifq_pkg;

    localparam int          PC_W         = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [0:0] {
        IFQ_RUN   = 1'b0,
        IFQ_DRAIN = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus_4;
    } ifq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_chk.sv
// -----------------------------------------------------------------------------
// ifq_fifo_chk
// Property checker attached to every ifq_fifo instance. Flags a push into a
// full FIFO without a matching pop, and a pop from an empty FIFO (for the tag
// FIFO that means a memory response with no request outstanding).
// Ports: clk, rst, clear, push, pop, count (current fill level).
// -----------------------------------------------------------------------------
module ifq_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          clear,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || clear)
        !(push && !pop && (count == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst || clear)
        !(pop && (count == CW'(0))));

endmodule

// File: rtl/inst_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo
// Synchronous FIFO with first-word fall-through read data.
// Ports: clk, rst (sync, active-high), clear (sync flush, wins over push),
//        push/wdata, pop, rdata (head entry), count (fill level).
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (r_count != CW'(0));
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and fill-level bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

    ifq_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .count (r_count)
    );

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Fetch stage in front of IF/ID: issues in-order word fetches, queues the
// returned instructions with their PC+4 and hands one per cycle to decode.
// A redirect flushes the queue and drops responses still in flight.
//
// Ports:
//   clock, reset                     - clock, synchronous active-high reset
//   imem_req_valid/ready/addr        - fetch request channel
//   imem_rsp_valid/data              - in-order fetch responses
//   redirect_valid/pc                - taken branch/jump target
//   id_stall                         - decode cannot take an instruction
//   if_valid, if_inst, if_pc_plus_4  - instruction to IF/ID (zeros when idle)
//   occupancy                        - instruction-queue fill level
//
// Build option: define IFQ_BYPASS_EN to let a response reach decode in the
// same cycle when the queue is empty (zero-latency path).
// -----------------------------------------------------------------------------
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [31:0]                 imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [31:0]                 imem_rsp_data,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        id_stall,
    output logic                        if_valid,
    output logic [31:0]                 if_inst,
    output logic [31:0]                 if_pc_plus_4,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [0:0] S_RUN   = 1'(IFQ_RUN);
    localparam logic [0:0] S_DRAIN = 1'(IFQ_DRAIN);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_drop_cnt;
    logic [0:0]    r_state;

    logic [CW-1:0] w_ent_count;
    logic [CW-1:0] w_tag_count;
    ifq_entry_t    w_ent_head;
    ifq_entry_t    w_new_entry;
    ifq_entry_t    w_if_entry;
    logic [31:0]   w_tag_head;
    logic [CW-1:0] w_redirect_drop;
    logic          w_ent_empty;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_rsp_live;
    logic          w_ent_push;
    logic          w_ent_pop;
    logic          w_if_valid;

    assign w_ent_empty = (w_ent_count == CW'(0));

    // Queued entries plus requests in flight may never exceed DEPTH; both
    // counts are registered, so a pop frees a credit only on the next cycle.
    assign w_credit = ({1'b0, w_ent_count} + {1'b0, w_tag_count}) < (CW+1)'(DEPTH);

    assign imem_req_valid = !reset && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // The tag FIFO head is always the PC of the oldest response in flight.
    assign w_new_entry.inst      = imem_rsp_data;
    assign w_new_entry.pc_plus_4 = w_tag_head + 32'd4;

    assign w_rsp_live = imem_rsp_valid && (r_state == S_RUN) && !redirect_valid;
    assign w_ent_pop  = !w_ent_empty && !id_stall && !redirect_valid;

    // A response on an empty queue still has to respect its tag FIFO order, so
    // the response that arrives in the redirect cycle is dropped, not counted.
    assign w_redirect_drop = w_tag_count - CW'(imem_rsp_valid);

`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = w_rsp_live && w_ent_empty && !reset;
    // A bypassed response that decode takes right away never enters the queue.
    assign w_ent_push = w_rsp_live && !(w_bypass && !id_stall);
`else
    assign w_ent_push = w_rsp_live;
`endif

    // Select what decode sees this cycle.
    always_comb begin
        w_if_valid = 1'b0;
        w_if_entry = '{inst: NOP_INST, pc_plus_4: 32'h0000_0000};
        if (reset) begin
            w_if_valid = 1'b0;
        end
`ifdef IFQ_BYPASS_EN
        else if (w_bypass) begin
            w_if_valid = 1'b1;
            w_if_entry = w_new_entry;
        end
`endif
        else if (!w_ent_empty) begin
            w_if_valid = 1'b1;
            w_if_entry = w_ent_head;
        end else begin
            w_if_valid = 1'b0;
        end
    end

    assign if_valid     = w_if_valid;
    assign if_inst      = w_if_entry.inst;
    assign if_pc_plus_4 = w_if_entry.pc_plus_4;
    assign occupancy    = w_ent_count;

    // Fetch PC, stale-response counter and RUN/DRAIN state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= CW'(0);
            r_state    <= S_RUN;
        end else if (redirect_valid) begin
            r_fetch_pc <= word_align(redirect_pc);
            r_drop_cnt <= w_redirect_drop;
            r_state    <= (w_redirect_drop != CW'(0)) ? S_DRAIN : S_RUN;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if ((r_state == S_DRAIN) && imem_rsp_valid) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
                if (r_drop_cnt == CW'(1)) begin
                    r_state <= S_RUN;
                end
            end
        end
    end

    ifq_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ifq_entry_t))) u_entry_fifo (
        .clk   (clock),
        .rst   (reset),
        .clear (redirect_valid),
        .push  (w_ent_push),
        .wdata (w_new_entry),
        .pop   (w_ent_pop),
        .rdata (w_ent_head),
        .count (w_ent_count)
    );

    // Outstanding-request PCs; never flushed, since dropped responses still
    // arrive and must consume their tags.
    ifq_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_fifo (
        .clk   (clock),
        .rst   (reset),
        .clear (1'b0),
        .push  (w_req_fire),
        .wdata (r_fetch_pc),
        .pop   (imem_rsp_valid),
        .rdata (w_tag_head),
        .count (w_tag_count)
    );

endmodule
